// File: rtl/rv32_multicycle_ctrl.sv
// rv32_multicycle_ctrl: multi-cycle control FSM for an RV32I core sharing one memory port
// between fetch and data access; owns instret, the memory-wait timeout and halt/trap state.
module rv32_multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opCode,
   input  logic [2:0]       funct3,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rg_re1,
   output logic             rg_re2,
   output logic             rg_we,
   output logic             alu_a_sel,
   output logic             alu_b_sel,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic             illegal
);
   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT, TRAP} state_t;
   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);
   state_t st, nxt;
   logic [TW-1:0] tcnt;
   logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, is_fence, is_sys;
   logic known, act, mem_ph, tout, commit, in_wb;
   assign is_r     = opCode == 7'b0110011;
   assign is_i     = opCode == 7'b0010011;
   assign is_ld    = opCode == 7'b0000011;
   assign is_st    = opCode == 7'b0100011;
   assign is_br    = opCode == 7'b1100011;
   assign is_jal   = opCode == 7'b1101111;
   assign is_jalr  = opCode == 7'b1100111;
   assign is_lui   = opCode == 7'b0110111;
   assign is_auipc = opCode == 7'b0010111;
   assign is_fence = opCode == 7'b0001111;
   assign is_sys   = opCode == 7'b1110011;
   assign known    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_auipc | is_fence | is_sys;
   // Strobes are forced low while rst is held so a pending store can never be written.
   assign act      = !rst;
   assign mem_ph   = st == FETCH || st == MEM;
   assign tout     = mem_ph && !mem_ready && tcnt == T_LAST;
   assign in_wb    = act && st == WB;
   assign commit   = in_wb || (act && st == MEM && is_st && mem_ready);
   assign state    = st;
   always_comb begin
      nxt = st;
      case (st)
         FETCH:   nxt = mem_ready ? DECODE : tout ? TRAP : FETCH;
         DECODE:  nxt = !known ? TRAP : is_sys ? (funct3 == 3'b000 ? HALT : TRAP) : EXECUTE;
         EXECUTE: nxt = (is_ld || is_st) ? MEM : WB;
         MEM:     nxt = mem_ready ? (is_st ? FETCH : WB) : tout ? TRAP : MEM;
         WB:      nxt = FETCH;
         default: nxt = st;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= FETCH;
         tcnt    <= '0;
         instret <= '0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         st      <= nxt;
         tcnt    <= (mem_ph && !mem_ready) ? tcnt + 1'b1 : '0;
         instret <= instret + CNT_W'(commit);
         halted  <= halted | (nxt == HALT);
         illegal <= illegal | (nxt == TRAP);
      end
   end
   always_comb begin
      mem_req      = act && mem_ph;
      mem_addr_sel = act && st == MEM;
      mem_we       = act && st == MEM && is_st;
      ir_we        = act && st == FETCH && mem_ready;
      pc_we        = commit;
      rg_re1       = act && st == DECODE;
      rg_re2       = act && st == DECODE;
      rg_we        = in_wb && (is_r || is_i || is_ld || is_jal || is_jalr || is_lui || is_auipc);
      alu_a_sel    = act && st == EXECUTE && (is_auipc || is_jal || is_br);
      alu_b_sel    = act && st == EXECUTE && !(is_r || is_br);
      pc_sel       = !in_wb ? 2'b00 : (is_jal || (is_br && branch_taken)) ? 2'b01 : is_jalr ? 2'b10 : 2'b00;
      wb_sel       = !in_wb ? 2'b00 : is_ld ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_lui ? 2'b11 : 2'b00;
   end
endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// tb_rv32_multicycle_ctrl: vector table, randomized instruction traces against a
// per-instruction cycle model, and directed halt/trap/timeout/reset sequences.
module tb_rv32_multicycle_ctrl;
   localparam int CW = 4, TO = 4;
   localparam logic [16:0] SMV = 17'h03670;
   typedef struct packed {
      logic [2:0] st;
      logic req, we, maddr, irwe, pcwe;
      logic [1:0] pcsel;
      logic re1, re2, rgwe, asel, bsel;
      logic [1:0] wbsel;
   } ov_t;
   typedef struct { logic rdy; ov_t o; ov_t m; } cyc_t;
   typedef struct {
      logic [31:0] w; logic bt; int wf, wm, cyc;
      logic [1:0] pcsel, wbsel; logic rgwe; int nwe, naddr, nwb;
   } vec_t;
   logic clk = 0, rst = 1, bt = 0, mem_ready = 0;
   logic [31:0] iw = 0;
   logic mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rg_re1, rg_re2, rg_we, alu_a_sel, alu_b_sel;
   logic [1:0] pc_sel, wb_sel;
   logic [2:0] state;
   logic [CW-1:0] instret;
   logic halted, illegal;
   ov_t outv, obs;
   int checks = 0, errors = 0, cnt = 0;
   cyc_t q[$];
   vec_t tbl[12];
   logic [6:0] ops[10];
   rv32_multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .opCode(iw[6:0]), .funct3(iw[14:12]), .branch_taken(bt),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
      .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rg_re1(rg_re1), .rg_re2(rg_re2),
      .rg_we(rg_we), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
      .state(state), .instret(instret), .halted(halted), .illegal(illegal)
   );
   assign outv = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
                  rg_re1, rg_re2, rg_we, alu_a_sel, alu_b_sel, wb_sel};
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask
   // Called at a falling edge: drive mem_ready, sample outputs, wait for the next falling edge.
   task automatic tick(input logic rdy);
      mem_ready = rdy;
      #2;
      obs = outv;
      @(negedge clk);
   endtask
   task automatic do_rst();
      logic [16:0] va;
      rst = 1; mem_ready = 1; bt = 1;
      #2;
      va = outv;
      chk("rst_strobes", 32'(va & SMV), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 0; bt = 0; cnt = 0;
      chk("rst_state", 32'(state), 0);
      chk("rst_instret", 32'(instret), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_illegal", 32'(illegal), 0);
   endtask
   // Expands one legal, non-SYSTEM instruction into its expected cycle trace.
   task automatic gen(input logic [31:0] w, input int wf, input int wm);
      logic [6:0] op;
      logic ld, sto, br, jal, jalr, lui, auipc, isr, fence;
      ov_t o, m, base;
      op = w[6:0];
      ld = op == 7'h03; sto = op == 7'h23; br = op == 7'h63; jal = op == 7'h6F; jalr = op == 7'h67;
      lui = op == 7'h37; auipc = op == 7'h17; isr = op == 7'h33; fence = op == 7'h0F;
      base = SMV;
      base.st = 3'h7;
      for (int k = 0; k <= wf; k++) begin
         o = '0; o.req = 1; o.irwe = k == wf;
         m = base; m.maddr = 1;
         q.push_back('{k == wf, o, m});
      end
      o = '0; o.st = 3'd1; o.re1 = 1; o.re2 = 1;
      q.push_back('{1'($urandom), o, base});
      o = '0; o.st = 3'd2; o.asel = auipc | jal | br; o.bsel = !(isr | br);
      m = base; m.asel = 1; m.bsel = 1;
      q.push_back('{1'($urandom), o, m});
      if (ld | sto)
         for (int k = 0; k <= wm; k++) begin
            o = '0; o.st = 3'd3; o.req = 1; o.maddr = 1; o.we = sto; o.pcwe = sto && k == wm;
            m = base; m.maddr = 1; m.pcsel = {2{sto && k == wm}};
            q.push_back('{k == wm, o, m});
         end
      if (!sto) begin
         o = '0; o.st = 3'd4; o.pcwe = 1; o.rgwe = !(br | fence);
         o.wbsel = ld ? 2'd1 : (jal | jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
         o.pcsel = (jal | (br & bt)) ? 2'd1 : jalr ? 2'd2 : 2'd0;
         m = base; m.pcsel = 2'b11; m.wbsel = 2'b11;
         q.push_back('{1'($urandom), o, m});
      end
   endtask
   task automatic run_q();
      cyc_t e;
      logic [16:0] va, vm, ve;
      while (q.size() > 0) begin
         e = q.pop_front();
         tick(e.rdy);
         va = obs; vm = e.m; ve = e.o;
         chk($sformatf("trace_st%0d", e.o.st), 32'(va & vm), 32'(ve & vm));
      end
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int c, fw, mw, nwe, naddr, nwb, nrg;
      logic [1:0] ps, ws;
      logic done, rdy;
      logic [31:0] w;
      logic [16:0] va;
      tbl[0]  = '{32'h00000033, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b1, 0, 0, 1};
      tbl[1]  = '{32'h0000A103, 1'b0, 0, 3, 8, 2'd0, 2'd1, 1'b1, 0, 4, 1};
      tbl[2]  = '{32'h00008063, 1'b1, 0, 0, 4, 2'd1, 2'd0, 1'b0, 0, 0, 1};
      tbl[3]  = '{32'h00008063, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b0, 0, 0, 1};
      tbl[4]  = '{32'h00008067, 1'b0, 0, 0, 4, 2'd2, 2'd2, 1'b1, 0, 0, 1};
      tbl[5]  = '{32'h00112023, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b0, 1, 1, 0};
      tbl[6]  = '{32'h0000006F, 1'b0, 0, 0, 4, 2'd1, 2'd2, 1'b1, 0, 0, 1};
      tbl[7]  = '{32'h00000037, 1'b0, 0, 0, 4, 2'd0, 2'd3, 1'b1, 0, 0, 1};
      tbl[8]  = '{32'h00000017, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b1, 0, 0, 1};
      tbl[9]  = '{32'h0000000F, 1'b0, 0, 0, 4, 2'd0, 2'd0, 1'b0, 0, 0, 1};
      tbl[10] = '{32'h00112023, 1'b0, 1, 2, 7, 2'd0, 2'd0, 1'b0, 3, 3, 0};
      tbl[11] = '{32'h00000013, 1'b0, 2, 0, 6, 2'd0, 2'd0, 1'b1, 0, 0, 1};
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F};
      do_rst();
      for (int t = 0; t < 12; t++) begin
         iw = tbl[t].w; bt = tbl[t].bt;
         c = 0; fw = 0; mw = 0; nwe = 0; naddr = 0; nwb = 0; nrg = 0; ps = 0; ws = 0; done = 0;
         while (!done && c < 40) begin
            if (state == 3'd0) begin rdy = fw == tbl[t].wf; fw++; end
            else if (state == 3'd3) begin rdy = mw == tbl[t].wm; mw++; end
            else rdy = 1'($urandom);
            tick(rdy);
            c++;
            nwe   += int'(obs.req & obs.we);
            naddr += int'(obs.req & obs.maddr);
            nrg   += int'(obs.rgwe);
            if (obs.st == 3'd4) begin nwb++; ws = obs.wbsel; end
            if (obs.pcwe) begin done = 1; ps = obs.pcsel; end
         end
         cnt++;
         chk($sformatf("vec%0d_cycles", t), 32'(c), 32'(tbl[t].cyc));
         chk($sformatf("vec%0d_pc_sel", t), 32'(ps), 32'(tbl[t].pcsel));
         chk($sformatf("vec%0d_wb_sel", t), 32'(ws), 32'(tbl[t].wbsel));
         chk($sformatf("vec%0d_rg_we", t), 32'(nrg), 32'(tbl[t].rgwe));
         chk($sformatf("vec%0d_mem_we", t), 32'(nwe), 32'(tbl[t].nwe));
         chk($sformatf("vec%0d_mem_addr", t), 32'(naddr), 32'(tbl[t].naddr));
         chk($sformatf("vec%0d_wb_cycles", t), 32'(nwb), 32'(tbl[t].nwb));
         chk($sformatf("vec%0d_instret", t), 32'(instret), 32'(cnt % 16));
      end
      for (int n = 0; n < 200; n++) begin
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 9)];
         iw = w;
         bt = 1'($urandom);
         gen(w, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)));
         run_q();
         cnt++;
         chk("rand_instret", 32'(instret), 32'(cnt % 16));
      end
      do_rst();
      iw = 32'h00100073;
      tick(1); tick(0);
      chk("halt_enter", 32'(state), 5);
      for (int k = 0; k < 20; k++) begin
         tick(1'($urandom));
         va = obs;
         chk("halt_strobes", 32'(va & SMV), 0);
         chk("halt_hold", 32'(obs.st), 5);
         chk("halted", 32'(halted), 1);
      end
      chk("halt_instret", 32'(instret), 0);
      chk("halt_illegal", 32'(illegal), 0);
      do_rst();
      iw = 32'h0000007F;
      tick(1); tick(0);
      for (int k = 0; k < 5; k++) begin
         tick(1'($urandom));
         va = obs;
         chk("trap_strobes", 32'(va & SMV), 0);
         chk("trap_hold", 32'(obs.st), 6);
         chk("illegal", 32'(illegal), 1);
         chk("trap_halted", 32'(halted), 0);
      end
      do_rst();
      iw = 32'h00001073;
      tick(1); tick(0);
      chk("sys_f3_trap", 32'(state), 6);
      do_rst();
      iw = 32'h00000033;
      repeat (3) tick(0);
      chk("fetch_wait3", 32'(state), 0);
      tick(0);
      chk("fetch_timeout", 32'(state), 6);
      chk("fetch_timeout_illegal", 32'(illegal), 1);
      do_rst();
      repeat (3) tick(0);
      tick(1);
      chk("fetch_edge_ir_we", 32'(obs.irwe), 1);
      chk("fetch_edge_state", 32'(state), 1);
      do_rst();
      iw = 32'h0000A103;
      tick(1); tick(0); tick(0);
      repeat (3) tick(0);
      chk("mem_wait3", 32'(state), 3);
      tick(0);
      chk("mem_timeout", 32'(state), 6);
      do_rst();
      iw = 32'h00112023;
      tick(1); tick(0); tick(0); tick(0);
      chk("store_mem_we", 32'(obs.we), 1);
      rst = 1; mem_ready = 1;
      #2;
      chk("rst_mid_mem_we", 32'(mem_we), 0);
      chk("rst_mid_mem_req", 32'(mem_req), 0);
      chk("rst_mid_pc_we", 32'(pc_we), 0);
      @(negedge clk);
      chk("rst_mid_state", 32'(state), 0);
      chk("rst_mid_instret", 32'(instret), 0);
      rst = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
